serial_word_shifter: RTL and testbench

Parallel-to-serial stage directly upstream of the serial pattern detector. Accepts WIDTH-bit words over a valid/ready handshake and drives them MSB-first, one bit per clock, onto a single serial line. The detector's `Input` is driven by this line. Between words the line idles high, so an idle line never presents a run of zeros downstream.

---
 rtl/serial_word_shifter.sv | 131 +++++++++++++
 tb/tb_serial_word_shifter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial shifter: WIDTH-bit words in over valid/ready, MSB-first bit stream out; line idles high.
// Define SERIAL_PARITY_EN to append an even-parity bit after each word's LSB.
module serial_word_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t          state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            serial_q, serial_d;
  logic            busy_q, busy_d;
  logic            fs_q, fs_d;
  logic            ready;
  logic            accept;
`ifdef SERIAL_PARITY_EN
  logic            par_q, par_d;
`endif

  // serial_q holds the bit currently on the line; shreg holds the bits still to come,
  // so shreg's MSB is always the next bit to present.
  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    cnt_d    = cnt;
    serial_d = serial_q;
    busy_d   = busy_q;
    fs_d     = 1'b0;
    ready    = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_d    = par_q;
`endif

    case (state)
      IDLE: begin
        ready    = 1'b1;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
      SHIFT: begin
        if (cnt != '0) begin
          serial_d = shreg[WIDTH-1];
          shreg_d  = {shreg[WIDTH-2:0], 1'b0};
          cnt_d    = cnt - CW'(1);
        end else begin
`ifdef SERIAL_PARITY_EN
          state_d  = PARITY;
          serial_d = par_q;
`else
          ready    = 1'b1;
          state_d  = IDLE;
          serial_d = 1'b1;
          busy_d   = 1'b0;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        ready    = 1'b1;
        state_d  = IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
`endif
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase

    accept = data_valid & ready;
    if (accept) begin
      state_d  = SHIFT;
      serial_d = data_in[WIDTH-1];
      shreg_d  = {data_in[WIDTH-2:0], 1'b0};
      cnt_d    = CW'(WIDTH - 1);
      busy_d   = 1'b1;
      fs_d     = 1'b1;
`ifdef SERIAL_PARITY_EN
      par_d    = ^data_in;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      fs_q     <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      cnt      <= cnt_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      fs_q     <= fs_d;
`ifdef SERIAL_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign data_ready  = ready;
  assign serial_out  = serial_q;
  assign busy        = busy_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Scoreboard bench for serial_word_shifter: driver pushes hand-computed bit streams, monitor pops per line cycle.
module tb_serial_word_shifter;
  localparam int unsigned WIDTH = 8;
`ifdef SERIAL_PARITY_EN
  localparam int PERIOD = WIDTH + 1;
`else
  localparam int PERIOD = WIDTH;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             data_valid = 1'b0;
  logic             data_ready;
  logic             serial_out;
  logic             frame_start;
  logic             busy;

  typedef struct packed {
    logic sbit;
    logic fs;
    logic rdy;
    logic gapless;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fs = -1000;

  serial_word_shifter #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .serial_out (serial_out),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one sample per line cycle, just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (reset_n && busy) begin
        check("bit_expected", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("serial_bit", {31'd0, serial_out}, {31'd0, e.sbit});
          check("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
          check("ready_in_word", {31'd0, data_ready}, {31'd0, e.rdy});
          if (e.fs) begin
            if (e.gapless) check("gapless_period", cyc - last_fs, PERIOD);
            last_fs = cyc;
          end
        end
      end else begin
        check("idle_serial", {31'd0, serial_out}, 32'd1);
        check("idle_ready", {31'd0, data_ready}, 32'd1);
        check("idle_frame_start", {31'd0, frame_start}, 32'd0);
        check("busy_dropped_mid_word", {31'd0, (q.size() != 0) && !q[0].fs}, 32'd0);
      end
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] bits, input logic par, input logic gapless);
    exp_t e;
    logic [WIDTH-1:0] b;
    b = bits;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      e.sbit    = b[i];
      e.fs      = (i == WIDTH - 1);
      e.gapless = gapless && (i == WIDTH - 1);
`ifdef SERIAL_PARITY_EN
      e.rdy     = 1'b0;
`else
      e.rdy     = (i == 0);
`endif
      q.push_back(e);
    end
`ifdef SERIAL_PARITY_EN
    e.sbit = par; e.fs = 1'b0; e.gapless = 1'b0; e.rdy = 1'b1;
    q.push_back(e);
`else
    if (par) e.sbit = e.sbit; // parity only exists in the parity build
`endif
  endtask

  // Offers w until accepted; leaves data_valid high so the next send can follow gaplessly.
  task automatic send(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] bits,
                      input logic par, input logic gapless);
    int n;
    n = 0;
    @(negedge clock);
    data_valid = 1'b1;
    data_in    = w;
    while (!data_ready && n < 4 * PERIOD) begin
      @(negedge clock);
      n++;
    end
    check("accept_timeout", {31'd0, data_ready}, 32'd1);
    if (data_ready) begin
      push_word(bits, par, gapless);
      @(posedge clock);
    end
  endtask

  task automatic drop();
    @(negedge clock);
    data_valid = 1'b0;
  endtask

  initial begin
    int n;
    #12;
    check("reset_serial", {31'd0, serial_out}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_frame_start", {31'd0, frame_start}, 32'd0);
    check("reset_ready", {31'd0, data_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);

    send(8'hA5, 8'b1010_0101, 1'b0, 1'b0);
    drop();
    repeat (PERIOD + 3) @(negedge clock);

    send(8'hFF, 8'b1111_1111, 1'b0, 1'b0);
    send(8'h00, 8'b0000_0000, 1'b0, 1'b1);
    drop();
    repeat (PERIOD + 3) @(negedge clock);

    // Offer a different word mid-shift; it must be ignored.
    send(8'h6E, 8'b0110_1110, 1'b1, 1'b0);
    drop();
    repeat (2) @(negedge clock);
    data_valid = 1'b1;
    data_in    = 8'h55;
    check("ready_mid_word", {31'd0, data_ready}, 32'd0);
    @(negedge clock);
    data_valid = 1'b0;
    repeat (PERIOD + 3) @(negedge clock);

    // Reset during bit 4 of 0x3C.
    send(8'h3C, 8'b0011_1100, 1'b0, 1'b0);
    drop();
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    q.delete();
    last_fs = -1000;
    #1;
    check("midreset_serial", {31'd0, serial_out}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_frame_start", {31'd0, frame_start}, 32'd0);
    check("midreset_ready", {31'd0, data_ready}, 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    send(8'h81, 8'b1000_0001, 1'b0, 1'b0);
    drop();
    repeat (PERIOD + 3) @(negedge clock);

    send(8'h07, 8'b0000_0111, 1'b1, 1'b0);
    drop();

    n = 0;
    while (q.size() != 0 && n < 4 * PERIOD) begin
      @(negedge clock);
      n++;
    end
    check("queue_drained", q.size(), 32'd0);
    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
